// File: rtl/pe_pix_sender_pkg.sv
// ------------------------------------------------------------------
// pe_pix_sender_pkg : shared widths, entry/job types and FSM states
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pe_pix_sender_pkg;

  localparam int PIX_WD     = 8;
  localparam int BUS_PIX    = 4;
  localparam int BEAT_WD    = PIX_WD * BUS_PIX;
  localparam int JOB_ADDR_WD = 10;
  localparam int JOB_LEN_WD  = 8;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_WD     = 2;

  typedef logic [BEAT_WD-1:0] beat_t;

  typedef struct packed {
    beat_t data;
    logic  last;
  } pix_ent_t;

  typedef struct packed {
    logic [JOB_ADDR_WD-1:0] base;
    logic [JOB_ADDR_WD-1:0] stride;
    logic [JOB_LEN_WD-1:0]  len;
    logic [JOB_LEN_WD-1:0]  rep;
  } job_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pe_pix_sender_skid.sv
// ------------------------------------------------------------------
// pix_skid_fifo : 2-entry {data, last} FIFO with registered head outputs
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pix_skid_fifo
  import pe_pix_sender_pkg::*;
#(
  parameter int DATA_WD = 32
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [DATA_WD-1:0] i_data,
  input  logic               i_last,
  input  logic               i_pop,
  output logic [DATA_WD-1:0] o_data,
  output logic               o_last,
  output logic               o_full,
  output logic               o_empty,
  output logic [CNT_WD-1:0]  o_cnt
);

  logic [DATA_WD-1:0] d0_q, d0_d, d1_q, d1_d;
  logic               l0_q, l0_d, l1_q, l1_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d;
  logic               do_pop, do_push;

  always_comb begin
    d0_d    = d0_q;
    d1_d    = d1_q;
    l0_d    = l0_q;
    l1_d    = l1_q;
    cnt_d   = cnt_q;
    do_pop  = i_pop & (cnt_q != '0);
    do_push = i_push & ((cnt_q != CNT_WD'(FIFO_DEPTH)) | do_pop);
    if (i_flush) begin
      cnt_d = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == '0) begin
            d0_d = i_data;
            l0_d = i_last;
          end else begin
            d1_d = i_data;
            l1_d = i_last;
          end
          cnt_d = cnt_q + CNT_WD'(1);
        end
        2'b01: begin
          d0_d  = d1_q;
          l0_d  = l1_q;
          cnt_d = cnt_q - CNT_WD'(1);
        end
        2'b11: begin
          // Occupancy is unchanged; the head advances and the new entry lands behind it.
          if (cnt_q == CNT_WD'(1)) begin
            d0_d = i_data;
            l0_d = i_last;
          end else begin
            d0_d = d1_q;
            l0_d = l1_q;
            d1_d = i_data;
            l1_d = i_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      d0_q  <= '0;
      d1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      d0_q  <= d0_d;
      d1_q  <= d1_d;
      l0_q  <= l0_d;
      l1_q  <= l1_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_data  = d0_q;
  assign o_last  = l0_q;
  assign o_cnt   = cnt_q;
  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == CNT_WD'(FIFO_DEPTH));

endmodule

`default_nettype wire

// File: rtl/pe_pix_sender.sv
// ------------------------------------------------------------------
// pe_pix_sender : streams strided SRAM beat runs (with replay) onto pbpix
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pe_pix_sender #(
  parameter int PIX_WD  = 8,
  parameter int BUS_PIX = 4,
  parameter int ADDR_WD = 10,
  parameter int LEN_WD  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_start,
  input  logic [ADDR_WD-1:0]        i_base,
  input  logic [ADDR_WD-1:0]        i_stride,
  input  logic [LEN_WD-1:0]         i_len,
  input  logic [LEN_WD-1:0]         i_rep,
  input  logic                      i_clear,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_sram_ce,
  output logic [ADDR_WD-1:0]        o_sram_addr,
  input  logic [PIX_WD*BUS_PIX-1:0] i_sram_rdata,
  output logic                      o_pix_val,
  input  logic                      i_pix_rdy,
  output logic [PIX_WD*BUS_PIX-1:0] o_pix_data,
  output logic                      o_pix_last
);

  import pe_pix_sender_pkg::*;

  logic [1:0]         state_q, state_d;
  logic [ADDR_WD-1:0] base_q, base_d, stride_q, stride_d, addr_q, addr_d;
  logic [LEN_WD-1:0]  len_q, len_d, rep_q, rep_d;
  logic [LEN_WD-1:0]  beat_cnt_q, beat_cnt_d, rep_cnt_q, rep_cnt_d;
  logic               inflight_q, inflight_d, inflight_last_q, inflight_last_d;

  logic               pop, push, issue, last_beat, last_pass;
  logic [CNT_WD:0]    occ;
  logic [CNT_WD-1:0]  fifo_cnt;
  logic               fifo_empty, fifo_full;

  assign pop  = o_pix_val & i_pix_rdy;
  // A read only lands when there is room for it, so the full guard never bites.
  assign push = inflight_q & (~fifo_full | pop);
  assign occ  = (CNT_WD+1)'(fifo_cnt) + (CNT_WD+1)'(inflight_q) - (CNT_WD+1)'(pop);
  assign issue = (state_q == ST_ISSUE) & ~i_clear & (occ < (CNT_WD+1)'(FIFO_DEPTH));
  assign last_beat = (beat_cnt_q == len_q);
  assign last_pass = (rep_cnt_q == rep_q);

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    stride_d        = stride_q;
    len_d           = len_q;
    rep_d           = rep_q;
    addr_d          = addr_q;
    beat_cnt_d      = beat_cnt_q;
    rep_cnt_d       = rep_cnt_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            base_d     = i_base;
            stride_d   = i_stride;
            len_d      = i_len;
            rep_d      = i_rep;
            addr_d     = i_base;
            beat_cnt_d = '0;
            rep_cnt_d  = '0;
            state_d    = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            inflight_d      = 1'b1;
            inflight_last_d = last_beat;
            if (last_beat) begin
              addr_d     = base_q;
              beat_cnt_d = '0;
              if (last_pass) state_d = ST_DRAIN;
              else rep_cnt_d = rep_cnt_q + LEN_WD'(1);
            end else begin
              addr_d     = addr_q + stride_q;
              beat_cnt_d = beat_cnt_q + LEN_WD'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Finish as the final beat is taken, so o_done follows acceptance by one cycle.
          if (!inflight_q && (fifo_empty || (fifo_cnt == CNT_WD'(1) && pop)))
            state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      stride_q        <= '0;
      len_q           <= '0;
      rep_q           <= '0;
      addr_q          <= '0;
      beat_cnt_q      <= '0;
      rep_cnt_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      stride_q        <= stride_d;
      len_q           <= len_d;
      rep_q           <= rep_d;
      addr_q          <= addr_d;
      beat_cnt_q      <= beat_cnt_d;
      rep_cnt_q       <= rep_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  pix_skid_fifo #(
    .DATA_WD (PIX_WD*BUS_PIX)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (i_clear),
    .i_push  (push),
    .i_data  (i_sram_rdata),
    .i_last  (inflight_last_q),
    .i_pop   (pop),
    .o_data  (o_pix_data),
    .o_last  (o_pix_last),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_cnt   (fifo_cnt)
  );

  assign o_pix_val   = ~fifo_empty;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_sram_ce   = issue;
  assign o_sram_addr = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_pix_sender.sv
// ------------------------------------------------------------------
// tb_pe_pix_sender : directed scenarios with a 1-cycle SRAM model
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pe_pix_sender;

  localparam int AW = 10;
  localparam int LW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn, start, clear, rdy;
  logic [AW-1:0] base, stride;
  logic [LW-1:0] len, rep;
  logic          busy, done, ce, pval, plast;
  logic [AW-1:0] saddr;
  logic [DW-1:0] rdata, pdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int ovf_err  = 0;
  int stab_err = 0;
  int outst    = 0;
  logic          stall_p = 1'b0;
  logic [DW-1:0] stall_d = '0;
  logic          stall_l = 1'b0;

  logic [AW-1:0] iss_q[$];
  logic [DW-1:0] acc_d[$];
  logic          acc_l[$];
  int            acc_c[$];

  always #5 clk = ~clk;

  pe_pix_sender #(
    .PIX_WD (8), .BUS_PIX (4), .ADDR_WD (AW), .LEN_WD (LW)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_base       (base),
    .i_stride     (stride),
    .i_len        (len),
    .i_rep        (rep),
    .i_clear      (clear),
    .o_busy       (busy),
    .o_done       (done),
    .o_sram_ce    (ce),
    .o_sram_addr  (saddr),
    .i_sram_rdata (rdata),
    .o_pix_val    (pval),
    .i_pix_rdy    (rdy),
    .o_pix_data   (pdata),
    .o_pix_last   (plast)
  );

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, 6'h15, a, ~a[7:0]};
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdata <= ce ? word(saddr) : 32'hDEADBEEF;
  end

  always @(negedge clk) begin
    if (ce) iss_q.push_back(saddr);
    if (pval && rdy) begin
      acc_d.push_back(pdata);
      acc_l.push_back(plast);
      acc_c.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (!rstn || clear) begin
      outst   <= 0;
      stall_p <= 1'b0;
    end else begin
      if ((outst + int'(ce) - int'(pval && rdy)) > 2) ovf_err <= ovf_err + 1;
      outst <= outst + int'(ce) - int'(pval && rdy);
      if (stall_p && (!pval || pdata !== stall_d || plast !== stall_l)) stab_err <= stab_err + 1;
      stall_p <= pval && !rdy;
    end
    stall_d <= pdata;
    stall_l <= plast;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] s,
                           input logic [LW-1:0] l, input logic [LW-1:0] r);
    base = b; stride = s; len = l; rep = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; clear = 1'b0; rdy = 1'b1;
    base = '0; stride = '0; len = '0; rep = '0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (ce !== 1'b0)    begin n_fail++; $display("FAIL reset_ce: got %b want 0", ce); end
    n_checks++; if (saddr !== '0)   begin n_fail++; $display("FAIL reset_addr: got %0d want 0", saddr); end
    n_checks++; if (pval !== 1'b0)  begin n_fail++; $display("FAIL reset_val: got %b want 0", pval); end
    n_checks++; if (pdata !== '0)   begin n_fail++; $display("FAIL reset_data: got %h want 0", pdata); end
    n_checks++; if (plast !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", plast); end
    rstn = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || ce !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b ce=%b want 0 0", busy, ce); end
  endtask

  task automatic test_single_beat();
    int i0 = iss_q.size();
    rdy = 1'b1;
    start_job(10'd5, 10'd1, 8'd0, 8'd0);
    n_checks++; if (busy !== 1'b1 || ce !== 1'b1 || saddr !== 10'd5) begin n_fail++; $display("FAIL single_issue: busy=%b ce=%b addr=%0d want 1 1 5", busy, ce, saddr); end
    n_checks++; if (pval !== 1'b0) begin n_fail++; $display("FAIL single_val_c0: got %b want 0", pval); end
    tick();
    n_checks++; if (pval !== 1'b0 || ce !== 1'b0) begin n_fail++; $display("FAIL single_c1: val=%b ce=%b want 0 0", pval, ce); end
    tick();
    n_checks++; if (pval !== 1'b1 || plast !== 1'b1 || pdata !== word(10'd5)) begin n_fail++; $display("FAIL single_beat: val=%b last=%b data=%h want 1 1 %h", pval, plast, pdata, word(10'd5)); end
    tick();
    n_checks++; if (done !== 1'b1 || pval !== 1'b0) begin n_fail++; $display("FAIL single_done: done=%b val=%b want 1 0", done, pval); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: done=%b busy=%b want 0 0", done, busy); end
    n_checks++; if (iss_q.size() - i0 != 1) begin n_fail++; $display("FAIL single_reads: got %0d want 1", iss_q.size() - i0); end
  endtask

  task automatic test_streaming();
    int i0 = iss_q.size();
    int a0 = acc_d.size();
    int d0 = done_cnt;
    bit ok = 0;
    logic [AW-1:0] ea;
    rdy = 1'b1;
    start_job(10'd0, 10'd3, 8'd7, 8'd1);
    for (int t = 0; t < 200; t++) begin
      tick();
      if (done_cnt != d0) begin ok = 1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stream_timeout: done never seen within 200 cycles"); end
    tick(); tick(); tick();
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL stream_done_count: got %0d want 1", done_cnt - d0); end
    n_checks++; if (iss_q.size() - i0 != 16) begin n_fail++; $display("FAIL stream_reads: got %0d want 16", iss_q.size() - i0); end
    n_checks++; if (acc_d.size() - a0 != 16) begin n_fail++; $display("FAIL stream_beats: got %0d want 16", acc_d.size() - a0); end
    if (iss_q.size() - i0 == 16 && acc_d.size() - a0 == 16) begin
      for (int k = 0; k < 16; k++) begin
        ea = AW'((k % 8) * 3);
        n_checks++; if (iss_q[i0+k] !== ea) begin n_fail++; $display("FAIL stream_addr[%0d]: got %0d want %0d", k, iss_q[i0+k], ea); end
        n_checks++; if (acc_d[a0+k] !== word(ea) || acc_l[a0+k] !== (k % 8 == 7)) begin n_fail++; $display("FAIL stream_beat[%0d]: data=%h last=%b want %h %b", k, acc_d[a0+k], acc_l[a0+k], word(ea), (k % 8 == 7)); end
      end
      n_checks++; if (acc_c[a0+15] - acc_c[a0] != 15) begin n_fail++; $display("FAIL stream_rate: span=%0d want 15", acc_c[a0+15] - acc_c[a0]); end
    end
  endtask

  task automatic test_backpressure();
    int i0 = iss_q.size();
    int a0 = acc_d.size();
    int d0 = done_cnt;
    int o0 = ovf_err;
    int s0 = stab_err;
    bit ok = 0;
    logic [AW-1:0] ea;
    rdy = 1'b0;
    start_job(10'd100, 10'd2, 8'd15, 8'd0);
    for (int t = 0; t < 2000; t++) begin
      rdy = ($urandom_range(0, 9) < 3);
      tick();
      if (done_cnt != d0) begin ok = 1; break; end
    end
    rdy = 1'b1;
    tick(); tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: done never seen within 2000 cycles"); end
    n_checks++; if (ovf_err != o0) begin n_fail++; $display("FAIL bp_outstanding: %0d cycles over 2 reads, want 0", ovf_err - o0); end
    n_checks++; if (stab_err != s0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stall cycles, want 0", stab_err - s0); end
    n_checks++; if (iss_q.size() - i0 != 16 || acc_d.size() - a0 != 16) begin n_fail++; $display("FAIL bp_count: reads=%0d beats=%0d want 16 16", iss_q.size() - i0, acc_d.size() - a0); end
    else begin
      for (int k = 0; k < 16; k++) begin
        ea = AW'(100 + 2 * k);
        n_checks++; if (acc_d[a0+k] !== word(ea) || acc_l[a0+k] !== (k == 15)) begin n_fail++; $display("FAIL bp_beat[%0d]: data=%h last=%b want %h %b", k, acc_d[a0+k], acc_l[a0+k], word(ea), (k == 15)); end
      end
    end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a[4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    int i0 = iss_q.size();
    int a0 = acc_d.size();
    int d0 = done_cnt;
    bit ok = 0;
    rdy = 1'b1;
    start_job(10'd1022, 10'd1, 8'd3, 8'd0);
    for (int t = 0; t < 100; t++) begin
      tick();
      if (done_cnt != d0) begin ok = 1; break; end
    end
    n_checks++; if (!ok || iss_q.size() - i0 != 4 || acc_d.size() - a0 != 4) begin n_fail++; $display("FAIL wrap_count: done=%0d reads=%0d beats=%0d want 1 4 4", ok, iss_q.size() - i0, acc_d.size() - a0); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (iss_q[i0+k] !== exp_a[k] || acc_d[a0+k] !== word(exp_a[k])) begin n_fail++; $display("FAIL wrap[%0d]: addr=%0d data=%h want %0d %h", k, iss_q[i0+k], acc_d[a0+k], exp_a[k], word(exp_a[k])); end
      end
    end
    tick();
  endtask

  task automatic test_abort();
    int i0;
    int a0 = acc_d.size();
    int d0 = done_cnt;
    int n_acc;
    bit ok = 0;
    logic [AW-1:0] ea;
    rdy = 1'b1;
    start_job(10'd200, 10'd1, 8'd9, 8'd0);
    for (int t = 0; t < 50; t++) begin
      if (acc_d.size() - a0 >= 3) begin ok = 1; break; end
      tick();
    end
    n_checks++; if (!ok || pval !== 1'b1) begin n_fail++; $display("FAIL abort_setup: reached=%0d val=%b want 1 1", ok, pval); end
    rdy = 1'b0; clear = 1'b1;
    base = 10'd900; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    n_acc = acc_d.size() - a0;
    n_checks++; if (pval !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_next: val=%b busy=%b done=%b want 0 0 0", pval, busy, done); end
    tick(); tick();
    n_checks++; if (pval !== 1'b0 || busy !== 1'b0 || ce !== 1'b0) begin n_fail++; $display("FAIL abort_quiet: val=%b busy=%b ce=%b want 0 0 0", pval, busy, ce); end
    n_checks++; if (done_cnt != d0 || acc_d.size() - a0 != n_acc) begin n_fail++; $display("FAIL abort_no_done: dones=%0d extra_beats=%0d want 0 0", done_cnt - d0, acc_d.size() - a0 - n_acc); end
    i0 = iss_q.size(); a0 = acc_d.size();
    rdy = 1'b1;
    start_job(10'd7, 10'd5, 8'd2, 8'd1);
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      if (done_cnt != d0) begin ok = 1; break; end
    end
    tick();
    n_checks++; if (!ok || iss_q.size() - i0 != 6 || acc_d.size() - a0 != 6) begin n_fail++; $display("FAIL abort_fresh_count: done=%0d reads=%0d beats=%0d want 1 6 6", ok, iss_q.size() - i0, acc_d.size() - a0); end
    else begin
      for (int k = 0; k < 6; k++) begin
        ea = AW'(7 + 5 * (k % 3));
        n_checks++; if (acc_d[a0+k] !== word(ea) || acc_l[a0+k] !== (k % 3 == 2)) begin n_fail++; $display("FAIL abort_fresh[%0d]: data=%h last=%b want %h %b", k, acc_d[a0+k], acc_l[a0+k], word(ea), (k % 3 == 2)); end
      end
    end
  endtask

  task automatic test_start_busy();
    int i0 = iss_q.size();
    int a0 = acc_d.size();
    int d0 = done_cnt;
    bit ok = 0;
    logic [AW-1:0] ea;
    rdy = 1'b1;
    start_job(10'd50, 10'd4, 8'd5, 8'd1);
    tick();
    start_job(10'd300, 10'd9, 8'd1, 8'd0);
    for (int t = 0; t < 100; t++) begin
      tick();
      if (done_cnt != d0) begin ok = 1; break; end
    end
    tick(); tick(); tick();
    n_checks++; if (!ok || busy !== 1'b0 || done_cnt - d0 != 1) begin n_fail++; $display("FAIL busy_start_done: seen=%0d busy=%b dones=%0d want 1 0 1", ok, busy, done_cnt - d0); end
    n_checks++; if (iss_q.size() - i0 != 12 || acc_d.size() - a0 != 12) begin n_fail++; $display("FAIL busy_start_count: reads=%0d beats=%0d want 12 12", iss_q.size() - i0, acc_d.size() - a0); end
    else begin
      for (int k = 0; k < 12; k++) begin
        ea = AW'(50 + 4 * (k % 6));
        n_checks++; if (iss_q[i0+k] !== ea || acc_d[a0+k] !== word(ea) || acc_l[a0+k] !== (k % 6 == 5)) begin n_fail++; $display("FAIL busy_start[%0d]: addr=%0d last=%b want %0d %b", k, iss_q[i0+k], acc_l[a0+k], ea, (k % 6 == 5)); end
      end
    end
  endtask

  task automatic test_reset_midjob();
    int a0;
    int d0;
    bit ok = 0;
    rdy = 1'b0;
    start_job(10'd400, 10'd1, 8'd9, 8'd0);
    tick(); tick(); tick(); tick();
    n_checks++; if (pval !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: val=%b busy=%b want 1 1", pval, busy); end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if ({busy, done, ce, pval, plast} !== 5'b0 || saddr !== '0 || pdata !== '0) begin n_fail++; $display("FAIL midrst_outputs: busy=%b done=%b ce=%b val=%b last=%b addr=%0d data=%h want all 0", busy, done, ce, pval, plast, saddr, pdata); end
    tick(); tick();
    rstn = 1'b1;
    tick();
    a0 = acc_d.size(); d0 = done_cnt;
    rdy = 1'b1;
    start_job(10'd33, 10'd1, 8'd0, 8'd0);
    for (int t = 0; t < 50; t++) begin
      tick();
      if (done_cnt != d0) begin ok = 1; break; end
    end
    n_checks++; if (!ok || acc_d.size() - a0 != 1 || acc_d[acc_d.size()-1] !== word(10'd33)) begin n_fail++; $display("FAIL midrst_recover: done=%0d beats=%0d want 1 1", ok, acc_d.size() - a0); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_abort();
    test_start_busy();
    test_reset_midjob();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
